// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // {mRead, mWrite}
    localparam logic [1:0] OP_NONE   = 2'b00;
    localparam logic [1:0] OP_STORE  = 2'b01;
    localparam logic [1:0] OP_LOAD   = 2'b10;
    localparam logic [1:0] OP_BUBBLE = 2'b11;

    localparam int WAIT_W = 4;

    function automatic logic is_access(input logic [1:0] op);
        return (op != OP_NONE) && (op != OP_BUBBLE);
    endfunction

endpackage

// File: rtl/dmem_wait_counter.sv
// Loadable down-counter with a zero flag that paces the responder's WAIT state.
module dmem_wait_counter
    import dmem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              dec,
    output logic              zero
);

    logic [WAIT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WAIT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Byte-addressed, big-endian data memory answering M-stage loads/stores with
// a programmable number of wait states and a stall to the hazard unit.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [15:0] addr,
    input  logic [15:0] wData,
    input  logic        mRead,
    input  logic        mWrite,
    input  logic        mByte,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        err,
    output logic        stall,
    output logic        busy
);

    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0]     DEPTH_L  = 17'(DEPTH);
    localparam logic [WAIT_W-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;

    function automatic logic check_fault(input logic [15:0] a, input logic is_byte);
        logic [16:0] a_ext;
        a_ext = {1'b0, a};
        return (a_ext >= DEPTH_L) ||
               (!is_byte && (a[0] || ((a_ext + 17'd1) >= DEPTH_L)));
    endfunction

    function automatic logic signed [15:0] sext8(input logic signed [7:0] b);
        return 16'(b);
    endfunction

    state_t      state;
    logic [7:0]  mem [DEPTH];

    logic [1:0]  op_in;
    logic        req_valid;

    logic [15:0] addr_p0;
    logic [15:0] wdata_p0;
    logic        byte_p0;
    logic [1:0]  op_p0;
    logic        fault_p0;

    logic [15:0] src_addr;
    logic        src_byte;
    logic        src_fault;
    logic [AW-1:0] src_idx;
    logic [AW-1:0] src_idx_lo;
    logic [15:0] rd_word;
    logic signed [15:0] rd_byte;
    logic [15:0] rd_data;

    logic        cnt_load;
    logic        cnt_dec;
    logic        cnt_zero;

    assign op_in     = {mRead, mWrite};
    assign req_valid = req && is_access(op_in);
    assign fault_p0  = check_fault(addr_p0, byte_p0);

    assign stall = reset && (((state == IDLE) && req_valid) || (state == WAIT));
    assign busy  = (state != IDLE);

    assign cnt_load = (state == IDLE) && req_valid;
    assign cnt_dec  = (state == WAIT) && !cnt_zero;

    dmem_wait_counter u_wait_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (CNT_INIT),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // With zero wait states the response is formed from the live inputs in IDLE.
    always_comb begin
        src_addr   = (state == IDLE) ? addr  : addr_p0;
        src_byte   = (state == IDLE) ? mByte : byte_p0;
        src_fault  = check_fault(src_addr, src_byte);
        src_idx    = src_addr[AW-1:0];
        src_idx_lo = src_idx + AW'(1);
        rd_word    = {mem[src_idx], mem[src_idx_lo]};
        rd_byte    = sext8(mem[src_idx]);
        rd_data    = src_fault ? 16'h0000 : (src_byte ? rd_byte : rd_word);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ack      <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
            addr_p0  <= '0;
            wdata_p0 <= '0;
            byte_p0  <= 1'b0;
            op_p0    <= OP_NONE;
        end else begin
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_p0  <= addr;
                        wdata_p0 <= wData;
                        byte_p0  <= mByte;
                        op_p0    <= op_in;
                        if (WAIT_CYCLES > 0) begin
                            state <= WAIT;
                        end else begin
                            state <= RESP;
                            ack   <= 1'b1;
                            err   <= src_fault;
                            rdata <= rd_data;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_zero) begin
                        state <= RESP;
                        ack   <= 1'b1;
                        err   <= src_fault;
                        rdata <= rd_data;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Stores commit on the edge that closes RESP; a reset before then drops them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if ((state == RESP) && (op_p0 == OP_STORE) && !fault_p0) begin
            if (byte_p0) begin
                mem[addr_p0[AW-1:0]] <= wdata_p0[7:0];
            end else begin
                mem[addr_p0[AW-1:0]]          <= wdata_p0[15:8];
                mem[addr_p0[AW-1:0] + AW'(1)] <= wdata_p0[7:0];
            end
        end
    end

endmodule
